router_input_port_vc: RTL and testbench
=======================================

Name: router_input_port_vc

Overview:
- Parametrised successor of the router's single-buffer input controller.
- Holds one DEPTH-deep FIFO per virtual channel (VC0/VC1, selected by flit bit VC_BIT).
- Serves the VC whose id equals `polarity` each cycle, XY-routes its head flit to one of NUM_OUT output controllers, and decrements the consumed hop field.
- Sits between an upstream link (or NIC) and the router's output controllers. Adds a north port, configurable field positions and widths, and stall-until-granted handling.

Parameters:
- DATA_W, 64, flit width.
- VC_BIT, 63, flit bit selecting VC.
- DIRX_BIT, 62, X direction bit (0 = east, 1 = west).
- DIRY_BIT, 61, Y direction bit (0 = north, 1 = south).
- HOP_W, 4, width of each hop field.
- HOPX_LSB, 52, LSB of X hop count.
- HOPY_LSB, 48, LSB of Y hop count.
- DEPTH, 2, entries per VC FIFO; power of two, at least 2.
- NUM_OUT, 5, number of output controllers.
- IDX_W / IDX_E / IDX_N / IDX_S / IDX_NIC, 0/1/2/3/4, output index per direction; all distinct and less than NUM_OUT.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, synchronous active-low reset; the block is in reset while reset==0.
- polarity, input, 1, VC served this cycle.
- upstream_si, input, 1, upstream flit valid.
- upstream_di, input, DATA_W, upstream flit.
- upstream_ri, output, 2, per-VC ready; bit v = VC v FIFO not full.
- out_ready, input, NUM_OUT, ready from each output controller.
- out_valid, output, NUM_OUT, one-hot-or-zero request to output controllers.
- out_data, output, DATA_W, updated flit, broadcast to all outputs.
- vc_count0, output, clog2(DEPTH)+1, VC0 occupancy.
- vc_count1, output, clog2(DEPTH)+1, VC1 occupancy.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-low.
- Reset:
  - On any clk edge with reset==0, both FIFOs empty: pointers 0, vc_count0/1 = 0.
  - While reset==0, upstream_ri forced 2'b00 and out_valid forced 0. Writes are ignored.
  - Reset mid-operation discards all stored flits, with no partial pop.
- Write:
  - v = upstream_di[VC_BIT].
  - Push into VC v on an edge where upstream_si && upstream_ri[v].
  - If upstream_si is high while VC v is full, the flit is dropped by the upstream's fault. The FIFO must not corrupt, and the count stays at DEPTH.
  - upstream_ri[v] = !full_v. It does not anticipate a same-cycle pop; no fall-through when full.
- Read VC: rv = polarity; head = FIFO_rv head; has_head = count_rv != 0.
- Route (combinational on head):
  - hx = head[HOPX_LSB+:HOP_W], hy = head[HOPY_LSB+:HOP_W].
  - If hx != 0: port = DIRX ? IDX_W : IDX_E; out_data = head with hx-1 in place.
  - Else if hy != 0: port = DIRY ? IDX_S : IDX_N; out_data = head with hy-1 in place.
  - Else: port = IDX_NIC; out_data = head unmodified.
  - All other bits pass unchanged, including VC_BIT. No underflow is possible because decrement occurs only when the field is nonzero.
- Output handshake:
  - out_valid[port] = has_head; all other out_valid bits are 0.
  - Pop FIFO_rv on an edge where out_valid[port] && out_ready[port].
  - If not granted, the head is retained unmodified; the decrement is applied only to the output copy, never written back.
  - Latency: a flit pushed at edge N is offered from cycle N+1 when polarity matches. Minimum 1 cycle.
- Polarity flip while stalled: the offer switches to the other VC's head; the stalled head stays at the front of its FIFO. out_valid may drop or move between cycles — this is intended (time-multiplexed VCs).
- Simultaneous events:
  - Push and pop on the same VC in one edge: count unchanged, order preserved, legal only when not full before the edge.
  - Push on VC a and pop on VC b: independent.
- Wrap-around: pointers are clog2(DEPTH) bits and wrap modulo DEPTH. Count saturates at neither end by construction.
- Ordering: strict FIFO within a VC; no ordering between VCs.

Decomposition:
- Package router_pkg holds:
  - Direction index constants (W/E/N/S/NIC).
  - Default field positions: VC_BIT, DIRX_BIT, DIRY_BIT, HOPX_LSB, HOPY_LSB, HOP_W.
  - A clog2 function.
- Sub-module vc_fifo (DATA_W, DEPTH): push/pop/full/empty/count/head. Instantiated twice.
- Route compute stays inline.

Test Plan:
- Reset:
  - Stimulus: reset=0 for 2 cycles with upstream_si=1 and flit 0x8000_0000_0000_0000, then reset=1.
  - Required: upstream_ri=00 and out_valid=0 during reset; after release upstream_ri=11 and vc_count0=vc_count1=0.
- X route:
  - Stimulus: push 0x0030_0000_0000_0001 (VC0, DIRX=0, hx=3, hy=0); polarity=0; out_ready=all 1.
  - Required: next cycle out_valid=5'b00010 (E) and out_data=0x0020_0000_0000_0001; pop; vc_count0 returns to 0.
- Y and NIC route:
  - Stimulus 1: VC1 flit 0xA001_0000_0000_0000 (DIRY=1, hy=1); polarity=1.
  - Required: out_valid=IDX_S and out_data=0xA000_0000_0000_0000.
  - Stimulus 2: then push 0x8000_0000_0000_0000.
  - Required: out_valid=IDX_NIC, data unchanged.
- Stall and polarity interleave:
  - Stimulus: VC0 head routes E with out_ready[E]=0 for 4 cycles; polarity toggles each cycle; VC1 holds a NIC flit.
  - Required: VC1 flit delivered on the first polarity=1 cycle; VC0 head still offered on polarity=0 cycles with identical out_data; popped on the cycle out_ready[E] rises with polarity=0.
- Full and wrap:
  - Stimulus: with DEPTH=2, push 3 flits on VC0 with out_ready=0.
  - Required: upstream_ri[0]=0 after 2 pushes; vc_count0=2; third flit not stored.
  - Stimulus: then drain and push 4 more.
  - Required: all delivered in order across pointer wrap.
- Concurrent push/pop:
  - Stimulus: VC0 count=1, same edge push VC0 and pop VC0.
  - Required: count stays 1 and the new flit is delivered next.
  - Stimulus: push VC1 while popping VC0.
  - Required: both counts update independently.

Source files
------------

// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared constants and helpers for the router input port
package router_pkg;

    localparam int DIR_IDX_W   = 0;
    localparam int DIR_IDX_E   = 1;
    localparam int DIR_IDX_N   = 2;
    localparam int DIR_IDX_S   = 3;
    localparam int DIR_IDX_NIC = 4;

    localparam int DEF_VC_BIT   = 63;
    localparam int DEF_DIRX_BIT = 62;
    localparam int DEF_DIRY_BIT = 61;
    localparam int DEF_HOPX_LSB = 52;
    localparam int DEF_HOPY_LSB = 48;
    localparam int DEF_HOP_W    = 4;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/vc_fifo.sv
// rtl/vc_fifo.sv - per-virtual-channel flit FIFO with occupancy count
module vc_fifo
    import router_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 2
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   push,
    input  logic [DATA_W-1:0]      push_data,
    input  logic                   pop,
    output logic                   full,
    output logic                   empty,
    output logic [clog2(DEPTH):0]  count,
    output logic [DATA_W-1:0]      head
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  cnt;
    logic              do_push;
    logic              do_pop;

    assign full    = (cnt == CNT_W'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign head    = mem[rd_ptr];
    // A push into a full FIFO is discarded so stored flits are never overwritten.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            cnt <= cnt + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/router_input_port_vc.sv
// rtl/router_input_port_vc.sv - two-VC router input port with XY route and hop decrement
module router_input_port_vc
    import router_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int VC_BIT   = DEF_VC_BIT,
    parameter int DIRX_BIT = DEF_DIRX_BIT,
    parameter int DIRY_BIT = DEF_DIRY_BIT,
    parameter int HOP_W    = DEF_HOP_W,
    parameter int HOPX_LSB = DEF_HOPX_LSB,
    parameter int HOPY_LSB = DEF_HOPY_LSB,
    parameter int DEPTH    = 2,
    parameter int NUM_OUT  = 5,
    parameter int IDX_W    = DIR_IDX_W,
    parameter int IDX_E    = DIR_IDX_E,
    parameter int IDX_N    = DIR_IDX_N,
    parameter int IDX_S    = DIR_IDX_S,
    parameter int IDX_NIC  = DIR_IDX_NIC
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   polarity,
    input  logic                   upstream_si,
    input  logic [DATA_W-1:0]      upstream_di,
    output logic [1:0]             upstream_ri,
    input  logic [NUM_OUT-1:0]     out_ready,
    output logic [NUM_OUT-1:0]     out_valid,
    output logic [DATA_W-1:0]      out_data,
    output logic [clog2(DEPTH):0]  vc_count0,
    output logic [clog2(DEPTH):0]  vc_count1
);

    localparam int CNT_W  = clog2(DEPTH) + 1;
    localparam int PORT_W = (NUM_OUT > 1) ? clog2(NUM_OUT) : 1;

    logic [1:0]        full;
    logic [1:0]        empty;
    logic [1:0]        push;
    logic [1:0]        pop;
    logic [DATA_W-1:0] head [2];
    logic [CNT_W-1:0]  count [2];

    logic [DATA_W-1:0] head_sel;
    logic              has_head;
    logic [HOP_W-1:0]  hx;
    logic [HOP_W-1:0]  hy;
    logic [PORT_W-1:0] port;
    logic              granted;

    for (genvar v = 0; v < 2; v++) begin : g_vc
        vc_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk       (clk),
            .resetn    (reset),
            .push      (push[v]),
            .push_data (upstream_di),
            .pop       (pop[v]),
            .full      (full[v]),
            .empty     (empty[v]),
            .count     (count[v]),
            .head      (head[v])
        );
    end

    assign vc_count0   = count[0];
    assign vc_count1   = count[1];
    assign upstream_ri = reset ? ~full : 2'b00;
    assign push        = (reset && upstream_si)
                       ? ((upstream_di[VC_BIT] ? 2'b10 : 2'b01) & ~full) : 2'b00;

    assign head_sel = head[polarity];
    assign has_head = reset && !empty[polarity];
    assign hx       = head_sel[HOPX_LSB +: HOP_W];
    assign hy       = head_sel[HOPY_LSB +: HOP_W];

    // The decremented hop is only on the output copy; the stored head stays intact until popped.
    always_comb begin
        out_data = head_sel;
        port     = PORT_W'(IDX_NIC);
        if (hx != '0) begin
            out_data[HOPX_LSB +: HOP_W] = hx - HOP_W'(1);
            port = head_sel[DIRX_BIT] ? PORT_W'(IDX_W) : PORT_W'(IDX_E);
        end else if (hy != '0) begin
            out_data[HOPY_LSB +: HOP_W] = hy - HOP_W'(1);
            port = head_sel[DIRY_BIT] ? PORT_W'(IDX_S) : PORT_W'(IDX_N);
        end
    end

    always_comb begin
        out_valid       = '0;
        out_valid[port] = has_head;
    end

    assign granted = has_head && out_ready[port];
    assign pop     = granted ? (polarity ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: tb/tb_router_input_port_vc.sv
// tb/tb_router_input_port_vc.sv - table, directed and randomized checks against a queue model
module tb_router_input_port_vc;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        polarity = 1'b0;
    logic        upstream_si = 1'b0;
    logic [63:0] upstream_di = '0;
    logic [1:0]  upstream_ri;
    logic [4:0]  out_ready = '0;
    logic [4:0]  out_valid;
    logic [63:0] out_data;
    logic [1:0]  vc_count0;
    logic [1:0]  vc_count1;

    int checks = 0;
    int errors = 0;

    logic [63:0] q0[$];
    logic [63:0] q1[$];

    router_input_port_vc dut (
        .clk         (clk),
        .reset       (reset),
        .polarity    (polarity),
        .upstream_si (upstream_si),
        .upstream_di (upstream_di),
        .upstream_ri (upstream_ri),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .vc_count0   (vc_count0),
        .vc_count1   (vc_count1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        pol;
        logic        si;
        logic [63:0] di;
        logic [4:0]  rdy;
        logic [1:0]  eri;
        logic [4:0]  eov;
        logic [63:0] edata;
        logic [1:0]  ec0;
        logic [1:0]  ec1;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Route rule written as field arithmetic on the whole flit.
    function automatic void ref_route(input logic [63:0] f, output int port, output logic [63:0] d);
        int hx;
        int hy;
        hx = int'((f >> 52) & 64'hF);
        hy = int'((f >> 48) & 64'hF);
        if (hx > 0) begin
            d = f - (64'd1 << 52);
            port = f[62] ? 0 : 1;
        end else if (hy > 0) begin
            d = f - (64'd1 << 48);
            port = f[61] ? 3 : 2;
        end else begin
            d = f;
            port = 4;
        end
    endfunction

    task automatic model_check(input string tag);
        logic [1:0]  eri;
        logic [4:0]  eov;
        logic [63:0] ed;
        int          port;
        int          n0;
        int          n1;
        n0 = q0.size();
        n1 = q1.size();
        eri = 2'b00;
        eov = 5'b0;
        ed = '0;
        if (reset) begin
            eri[0] = (n0 < DEPTH);
            eri[1] = (n1 < DEPTH);
            if (polarity ? (n1 > 0) : (n0 > 0)) begin
                ref_route(polarity ? q1[0] : q0[0], port, ed);
                eov = 5'(1 << port);
            end
        end
        chk({tag, " upstream_ri"}, 64'(upstream_ri), 64'(eri));
        chk({tag, " out_valid"}, 64'(out_valid), 64'(eov));
        if (eov != 0) chk({tag, " out_data"}, out_data, ed);
        chk({tag, " vc_count0"}, 64'(vc_count0), 64'(n0));
        chk({tag, " vc_count1"}, 64'(vc_count1), 64'(n1));
    endtask

    task automatic model_edge();
        logic [63:0] ed;
        int          port;
        logic        do_pop;
        logic        do_push;
        int          n0;
        int          n1;
        n0 = q0.size();
        n1 = q1.size();
        if (!reset) begin
            q0.delete();
            q1.delete();
        end else begin
            do_pop = 1'b0;
            if (polarity ? (n1 > 0) : (n0 > 0)) begin
                ref_route(polarity ? q1[0] : q0[0], port, ed);
                do_pop = out_ready[port];
            end
            do_push = upstream_si && ((upstream_di[63] ? n1 : n0) < DEPTH);
            if (do_pop) begin
                if (polarity) void'(q1.pop_front());
                else void'(q0.pop_front());
            end
            if (do_push) begin
                if (upstream_di[63]) q1.push_back(upstream_di);
                else q0.push_back(upstream_di);
            end
        end
    endtask

    task automatic drive(input logic r, input logic p, input logic s,
                         input logic [63:0] d, input logic [4:0] rd);
        @(negedge clk);
        reset = r;
        polarity = p;
        upstream_si = s;
        upstream_di = d;
        out_ready = rd;
        #1;
    endtask

    task automatic step(input string tag, input logic r, input logic p, input logic s,
                        input logic [63:0] d, input logic [4:0] rd);
        drive(r, p, s, d, rd);
        model_check(tag);
        model_edge();
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 1'b1, 64'h8000_0000_0000_0000, 5'h1F, 2'b00, 5'b00000, 64'h0, 2'd0, 2'd0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 64'h8000_0000_0000_0000, 5'h1F, 2'b00, 5'b00000, 64'h0, 2'd0, 2'd0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 64'h0,                   5'h1F, 2'b11, 5'b00000, 64'h0, 2'd0, 2'd0};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 64'h0030_0000_0000_0001, 5'h1F, 2'b11, 5'b00000, 64'h0, 2'd0, 2'd0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 64'h0,                   5'h1F, 2'b11, 5'b00010, 64'h0020_0000_0000_0001, 2'd1, 2'd0};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 64'hA001_0000_0000_0000, 5'h1F, 2'b11, 5'b00000, 64'h0, 2'd0, 2'd0};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 64'h8000_0000_0000_0000, 5'h1F, 2'b11, 5'b01000, 64'hA000_0000_0000_0000, 2'd0, 2'd1};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 64'h0,                   5'h1F, 2'b11, 5'b10000, 64'h8000_0000_0000_0000, 2'd0, 2'd1};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 64'h4010_0000_0000_0000, 5'h1F, 2'b11, 5'b00000, 64'h0, 2'd0, 2'd0};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 64'h0,                   5'h1F, 2'b11, 5'b00000, 64'h0, 2'd1, 2'd0};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 64'h0,                   5'h1F, 2'b11, 5'b00001, 64'h4000_0000_0000_0000, 2'd1, 2'd0};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 64'h0002_0000_0000_0005, 5'h00, 2'b11, 5'b00000, 64'h0, 2'd0, 2'd0};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 64'h0,                   5'h00, 2'b11, 5'b00100, 64'h0001_0000_0000_0005, 2'd1, 2'd0};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 64'h0,                   5'h1F, 2'b11, 5'b00100, 64'h0001_0000_0000_0005, 2'd1, 2'd0};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 64'h0,                   5'h1F, 2'b11, 5'b00000, 64'h0, 2'd0, 2'd0};

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].rst, vecs[i].pol, vecs[i].si, vecs[i].di, vecs[i].rdy);
            chk($sformatf("vec%0d upstream_ri", i), 64'(upstream_ri), 64'(vecs[i].eri));
            chk($sformatf("vec%0d out_valid", i), 64'(out_valid), 64'(vecs[i].eov));
            if (vecs[i].eov != 0) chk($sformatf("vec%0d out_data", i), out_data, vecs[i].edata);
            chk($sformatf("vec%0d vc_count0", i), 64'(vc_count0), 64'(vecs[i].ec0));
            chk($sformatf("vec%0d vc_count1", i), 64'(vc_count1), 64'(vecs[i].ec1));
            model_edge();
        end

        // Stall on E while polarity toggles; VC1 holds a NIC flit.
        step("stall_load0", 1'b1, 1'b0, 1'b1, 64'h0030_0000_0000_0001, 5'b11101);
        step("stall_load1", 1'b1, 1'b1, 1'b1, 64'h8000_0000_0000_00AA, 5'b11101);
        for (int i = 0; i < 4; i++) begin
            step($sformatf("stall%0d", i), 1'b1, 1'(i % 2), 1'b0, 64'h0, 5'b11101);
            if (i == 0) chk("stall0 held data", out_data, 64'h0020_0000_0000_0001);
            if (i == 1) chk("stall1 nic valid", 64'(out_valid), 64'h10);
        end
        step("stall_grant", 1'b1, 1'b0, 1'b0, 64'h0, 5'h1F);
        chk("stall_grant valid", 64'(out_valid), 64'h02);
        step("stall_done", 1'b1, 1'b0, 1'b0, 64'h0, 5'h1F);

        // Fill VC0 past capacity, then drain with concurrent push/pop across the wrap.
        for (int i = 0; i < 3; i++)
            step($sformatf("fill%0d", i), 1'b1, 1'b0, 1'b1, 64'h0000_0000_0000_0010 + 64'(i), 5'h00);
        drive(1'b1, 1'b0, 1'b0, 64'h0, 5'h00);
        chk("full ri0", 64'(upstream_ri[0]), 64'd0);
        chk("full count0", 64'(vc_count0), 64'd2);
        model_check("full");
        model_edge();
        step("drain0", 1'b1, 1'b0, 1'b0, 64'h0, 5'h1F);
        for (int i = 0; i < 4; i++)
            step($sformatf("wrap%0d", i), 1'b1, 1'b0, 1'b1, 64'h0000_0000_0000_0020 + 64'(i), 5'h1F);
        step("cross", 1'b1, 1'b0, 1'b1, 64'h8000_0000_0000_0030, 5'h1F);
        for (int i = 0; i < 3; i++)
            step($sformatf("drain_tail%0d", i), 1'b1, 1'(i), 1'b0, 64'h0, 5'h1F);

        // Mid-operation reset with flits queued.
        step("pre_rst", 1'b1, 1'b0, 1'b1, 64'h0010_0000_0000_0040, 5'h00);
        step("mid_rst", 1'b0, 1'b0, 1'b1, 64'h0010_0000_0000_0041, 5'h1F);
        step("post_rst", 1'b1, 1'b0, 1'b0, 64'h0, 5'h1F);

        for (int i = 0; i < 3000; i++) begin
            logic [63:0] d;
            d = {$urandom, $urandom};
            d[55:52] = 4'($urandom_range(0, 2));
            d[51:48] = 4'($urandom_range(0, 2));
            step("rand", ($urandom_range(0, 49) != 0), 1'($urandom), 1'($urandom),
                 d, 5'($urandom) | 5'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
